// File: rtl/retry_inorder_arbiter.sv
// Round-robin arbiter feeding one retry-protected in-order pipeline, with per-requester credit limits.
// Optional feature macro: RETRY_ARB_STATS_EN adds clearable, saturating per-requester grant counters.
module retry_inorder_arbiter #(
    parameter int unsigned NumReq         = 4,
    parameter int unsigned DataWidth      = 8,
    parameter int unsigned MaxOutstanding = 4,
    localparam int unsigned IdxWidth      = $clog2(NumReq),
    localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1)
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NumReq-1:0][DataWidth-1:0]   data_i,
    input  logic [NumReq-1:0]                  valid_i,
    output logic [NumReq-1:0]                  ready_o,
    output logic [DataWidth-1:0]               data_o,
    output logic [IdxWidth-1:0]                idx_o,
    output logic                               valid_o,
    input  logic                               ready_i,
    input  logic                               lock_i,
    input  logic                               done_valid_i,
    input  logic [IdxWidth-1:0]                done_idx_i,
    output logic [NumReq-1:0][CntWidth-1:0]    outstanding_o
`ifdef RETRY_ARB_STATS_EN
    ,
    input  logic                               stats_clear_i,
    output logic [NumReq-1:0][15:0]            grants_o
`endif
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_e;

    state_e                         state_q, state_d;
    logic [IdxWidth-1:0]            rr_ptr_q, rr_ptr_d;
    logic [IdxWidth-1:0]            held_q, held_d;
    logic [IdxWidth-1:0]            winner, cand, grant_idx;
    logic [NumReq-1:0][CntWidth-1:0] cnt_q;
    logic [NumReq-1:0]              eligible, inc, dec, cnt_zero;
    logic                           any_elig, grant_valid, handshake;

    // A requester may compete only while it has credits left.
    always_comb begin
        eligible = '0;
        cnt_zero = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            eligible[i] = valid_i[i] && (cnt_q[i] < CntWidth'(MaxOutstanding));
            cnt_zero[i] = (cnt_q[i] == '0);
        end
    end

    // Cyclic search for the first eligible requester at or after rr_ptr.
    always_comb begin
        winner   = '0;
        cand     = '0;
        any_elig = 1'b0;
        for (int unsigned off = 0; off < NumReq; off++) begin
            cand = IdxWidth'((32'(rr_ptr_q) + off) % NumReq);
            if (!any_elig && eligible[cand]) begin
                any_elig = 1'b1;
                winner   = cand;
            end
        end
    end

    // Next-state: IDLE grants fresh winners unless locked; HOLD pins the grant until accepted.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        held_d      = held_q;
        grant_valid = 1'b0;
        grant_idx   = '0;
        case (state_q)
            IDLE: begin
                if (!lock_i && any_elig) begin
                    grant_valid = 1'b1;
                    grant_idx   = winner;
                end
            end
            HOLD: begin
                grant_valid = 1'b1;
                grant_idx   = held_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        handshake = grant_valid && ready_i;
        if (handshake) begin
            rr_ptr_d = (grant_idx == IdxWidth'(NumReq - 1)) ? '0 : grant_idx + IdxWidth'(1);
            state_d  = IDLE;
        end else if (grant_valid && (state_q == IDLE)) begin
            state_d = HOLD;
            held_d  = grant_idx;
        end
    end

    // Zero-latency pipeline-side outputs; forced low while reset is asserted.
    always_comb begin
        valid_o = 1'b0;
        data_o  = '0;
        idx_o   = '0;
        ready_o = '0;
        if (grant_valid && rst_ni) begin
            valid_o            = 1'b1;
            data_o             = data_i[grant_idx];
            idx_o              = grant_idx;
            ready_o[grant_idx] = ready_i;
        end
    end

    always_comb begin
        inc = '0;
        dec = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            inc[i] = handshake && (grant_idx == IdxWidth'(i));
            dec[i] = done_valid_i && (done_idx_i == IdxWidth'(i));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            held_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            held_q   <= held_d;
            // Simultaneous grant and return on one index cancel out.
            for (int unsigned i = 0; i < NumReq; i++) begin
                if (inc[i] && !dec[i]) begin
                    cnt_q[i] <= cnt_q[i] + CntWidth'(1);
                end else if (dec[i] && !inc[i] && !cnt_zero[i]) begin
                    cnt_q[i] <= cnt_q[i] - CntWidth'(1);
                end
            end
        end
    end

    assign outstanding_o = cnt_q;

    hold_valid_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == HOLD) |-> valid_i[held_q]);

    credit_underflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (dec & ~inc & cnt_zero) == '0);

    done_idx_range_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        done_valid_i |-> (|dec));

`ifdef RETRY_ARB_STATS_EN
    localparam int unsigned StatsWidth = 16;

    logic [NumReq-1:0][StatsWidth-1:0] grants_q;

    // Saturating per-requester grant counters; a clear beats a same-cycle grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grants_q <= '0;
        end else if (stats_clear_i) begin
            grants_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NumReq; i++) begin
                if (inc[i] && (grants_q[i] != {StatsWidth{1'b1}})) begin
                    grants_q[i] <= grants_q[i] + StatsWidth'(1);
                end
            end
        end
    end

    assign grants_o = grants_q;
`endif

endmodule

// File: tb/tb_retry_inorder_arbiter.sv
// Table-driven bench for retry_inorder_arbiter: per-cycle stimulus rows with hand-computed outputs.
module tb_retry_inorder_arbiter;

    localparam int unsigned NumReq    = 4;
    localparam int unsigned DataWidth = 8;
    localparam int unsigned IdxWidth  = 2;
    localparam int unsigned CntWidth  = 3;

    logic                             clk_i = 1'b0;
    logic                             rst_ni = 1'b0;
    logic [NumReq-1:0][DataWidth-1:0] data_i;
    logic [NumReq-1:0]                valid_i = '0;
    logic [NumReq-1:0]                ready_o;
    logic [DataWidth-1:0]             data_o;
    logic [IdxWidth-1:0]              idx_o;
    logic                             valid_o;
    logic                             ready_i = 1'b0;
    logic                             lock_i = 1'b0;
    logic                             done_valid_i = 1'b0;
    logic [IdxWidth-1:0]              done_idx_i = '0;
    logic [NumReq-1:0][CntWidth-1:0]  outstanding_o;
`ifdef RETRY_ARB_STATS_EN
    logic                             stats_clear_i = 1'b0;
    logic [NumReq-1:0][15:0]          grants_o;
`endif

    int checks = 0;
    int errors = 0;

    retry_inorder_arbiter dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .data_i        (data_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .data_o        (data_o),
        .idx_o         (idx_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .lock_i        (lock_i),
        .done_valid_i  (done_valid_i),
        .done_idx_i    (done_idx_i),
        .outstanding_o (outstanding_o)
`ifdef RETRY_ARB_STATS_EN
        ,
        .stats_clear_i (stats_clear_i),
        .grants_o      (grants_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        pre_rst;
        logic [3:0]  valid;
        logic        ready;
        logic        lock;
        logic        dv;
        logic [1:0]  didx;
        logic        ev;
        logic [1:0]  eidx;
        logic [3:0]  erdy;
        logic [11:0] ecnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic pr, input logic [3:0] v, input logic r, input logic l,
                       input logic dv, input logic [1:0] di, input logic ev, input logic [1:0] ei,
                       input logic [3:0] er, input int c0, input int c1, input int c2, input int c3);
        vec_t t;
        t.pre_rst = pr;
        t.valid   = v;
        t.ready   = r;
        t.lock    = l;
        t.dv      = dv;
        t.didx    = di;
        t.ev      = ev;
        t.eidx    = ei;
        t.erdy    = er;
        t.ecnt    = {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni       = 1'b0;
        valid_i      = '0;
        ready_i      = 1'b0;
        lock_i       = 1'b0;
        done_valid_i = 1'b0;
        done_idx_i   = '0;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        vec_t   t;
        logic [7:0] exp_data;
        for (int i = 0; i < NumReq; i++) data_i[i] = 8'(8'hA0 + i);

        // Fairness: all valid, ready high, credit returned in the grant cycle.
        add(1, 4'b1111, 1, 0, 1, 0, 1, 0, 4'b0001, 0, 0, 0, 0);
        add(0, 4'b1111, 1, 0, 1, 1, 1, 1, 4'b0010, 0, 0, 0, 0);
        add(0, 4'b1111, 1, 0, 1, 2, 1, 2, 4'b0100, 0, 0, 0, 0);
        add(0, 4'b1111, 1, 0, 1, 3, 1, 3, 4'b1000, 0, 0, 0, 0);
        add(0, 4'b1111, 1, 0, 1, 0, 1, 0, 4'b0001, 0, 0, 0, 0);
        add(0, 4'b1111, 1, 0, 1, 1, 1, 1, 4'b0010, 0, 0, 0, 0);
        // Credit limit on requester 2, then one credit returned.
        add(0, 4'b0100, 1, 0, 0, 0, 1, 2, 4'b0100, 0, 0, 0, 0);
        add(0, 4'b0100, 1, 0, 0, 0, 1, 2, 4'b0100, 0, 0, 1, 0);
        add(0, 4'b0100, 1, 0, 0, 0, 1, 2, 4'b0100, 0, 0, 2, 0);
        add(0, 4'b0100, 1, 0, 0, 0, 1, 2, 4'b0100, 0, 0, 3, 0);
        add(0, 4'b0100, 1, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 4, 0);
        add(0, 4'b0100, 1, 0, 1, 2, 0, 0, 4'b0000, 0, 0, 4, 0);
        add(0, 4'b0100, 1, 0, 0, 0, 1, 2, 4'b0100, 0, 0, 3, 0);
        add(0, 4'b0100, 1, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 4, 0);
        // Hold on requester 1 while requester 0 rises; next grant wraps to 0.
        add(1, 4'b0010, 0, 0, 0, 0, 1, 1, 4'b0000, 0, 0, 0, 0);
        add(0, 4'b0011, 0, 0, 0, 0, 1, 1, 4'b0000, 0, 0, 0, 0);
        add(0, 4'b0011, 0, 0, 0, 0, 1, 1, 4'b0000, 0, 0, 0, 0);
        add(0, 4'b0011, 0, 0, 0, 0, 1, 1, 4'b0000, 0, 0, 0, 0);
        add(0, 4'b0011, 0, 0, 0, 0, 1, 1, 4'b0000, 0, 0, 0, 0);
        add(0, 4'b0011, 1, 0, 0, 0, 1, 1, 4'b0010, 0, 0, 0, 0);
        add(0, 4'b0011, 1, 0, 0, 0, 1, 0, 4'b0001, 0, 1, 0, 0);
        add(0, 4'b0000, 1, 0, 0, 0, 0, 0, 4'b0000, 1, 1, 0, 0);
        // Lock in IDLE, then lock raised during HOLD.
        add(1, 4'b1111, 1, 1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
        add(0, 4'b1111, 1, 1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
        add(0, 4'b1111, 1, 0, 0, 0, 1, 0, 4'b0001, 0, 0, 0, 0);
        add(0, 4'b1111, 0, 0, 0, 0, 1, 1, 4'b0000, 1, 0, 0, 0);
        add(0, 4'b1111, 0, 1, 0, 0, 1, 1, 4'b0000, 1, 0, 0, 0);
        add(0, 4'b1111, 1, 1, 0, 0, 1, 1, 4'b0010, 1, 0, 0, 0);
        add(0, 4'b1111, 1, 1, 0, 0, 0, 0, 4'b0000, 1, 1, 0, 0);
        add(0, 4'b1111, 1, 0, 0, 0, 1, 2, 4'b0100, 1, 1, 0, 0);
        // Same-cycle grant and credit return on requester 3 at count 2.
        add(1, 4'b1000, 1, 0, 0, 0, 1, 3, 4'b1000, 0, 0, 0, 0);
        add(0, 4'b1000, 1, 0, 0, 0, 1, 3, 4'b1000, 0, 0, 0, 1);
        add(0, 4'b1000, 1, 0, 1, 3, 1, 3, 4'b1000, 0, 0, 0, 2);
        add(0, 4'b0000, 1, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 2);
        // Build counts [1,2,0,3], then park in HOLD on requester 2.
        add(1, 4'b0001, 1, 0, 0, 0, 1, 0, 4'b0001, 0, 0, 0, 0);
        add(0, 4'b0010, 1, 0, 0, 0, 1, 1, 4'b0010, 1, 0, 0, 0);
        add(0, 4'b0010, 1, 0, 0, 0, 1, 1, 4'b0010, 1, 1, 0, 0);
        add(0, 4'b1000, 1, 0, 0, 0, 1, 3, 4'b1000, 1, 2, 0, 0);
        add(0, 4'b1000, 1, 0, 0, 0, 1, 3, 4'b1000, 1, 2, 0, 1);
        add(0, 4'b1000, 1, 0, 0, 0, 1, 3, 4'b1000, 1, 2, 0, 2);
        add(0, 4'b0100, 0, 0, 0, 0, 1, 2, 4'b0000, 1, 2, 0, 3);
        add(0, 4'b0100, 0, 0, 0, 0, 1, 2, 4'b0000, 1, 2, 0, 3);

        for (int r = 0; r < vecs.size(); r++) begin
            t = vecs[r];
            if (t.pre_rst) do_reset();
            @(negedge clk_i);
            valid_i      = t.valid;
            ready_i      = t.ready;
            lock_i       = t.lock;
            done_valid_i = t.dv;
            done_idx_i   = t.didx;
            #1;
            exp_data = t.ev ? 8'(8'hA0 + t.eidx) : 8'h00;
            chk($sformatf("row%0d valid_o", r), 32'(valid_o), 32'(t.ev));
            chk($sformatf("row%0d idx_o", r), 32'(idx_o), 32'(t.ev ? t.eidx : 2'd0));
            chk($sformatf("row%0d data_o", r), 32'(data_o), 32'(exp_data));
            chk($sformatf("row%0d ready_o", r), 32'(ready_o), 32'(t.erdy));
            chk($sformatf("row%0d outstanding_o", r), 32'(outstanding_o), 32'(t.ecnt));
        end

        // Asynchronous reset while holding requester 2 with counts [1,2,0,3].
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_rst valid_o", 32'(valid_o), 32'd0);
        chk("async_rst ready_o", 32'(ready_o), 32'd0);
        chk("async_rst data_o", 32'(data_o), 32'd0);
        chk("async_rst idx_o", 32'(idx_o), 32'd0);
        chk("async_rst outstanding_o", 32'(outstanding_o), 32'd0);

        @(negedge clk_i);
        valid_i = 4'b0110;
        ready_i = 1'b1;
        rst_ni  = 1'b1;
        #1;
        chk("post_rst valid_o", 32'(valid_o), 32'd1);
        chk("post_rst idx_o", 32'(idx_o), 32'd1);
        chk("post_rst data_o", 32'(data_o), 32'hA1);
        chk("post_rst ready_o", 32'(ready_o), 32'b0010);
        chk("post_rst outstanding_o", 32'(outstanding_o), 32'd0);
        @(posedge clk_i);
        #1;
        chk("post_rst count", 32'(outstanding_o), 32'h008);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
